// File: rtl/gba_timer_bank.sv
// gba_timer_bank
// Bank of NUM_CH GBA-style timers behind one 32-bit word-addressed register bus.
// Each channel has a reload value, a prescaler (1/64/256/1024), cascade count-up
// from the previous channel, an IRQ enable, start/stop and a one-shot mode.
// The cascade chain is combinational, so a full chain overflows in the same clock.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   gb_on      global enable; low freezes all channel state (bus still works)
//   bus_adr    word address (channel i at BASE_ADR+i)
//   bus_din    write data
//   bus_be     write byte enables (be[3] ignored)
//   bus_wr     write strobe
//   bus_rd     read strobe
//   bus_dout   read data, zero unless bus_rvalid
//   bus_rvalid read data valid, one cycle after bus_rd
//   tick       per-channel overflow pulse
//   irq        per-channel IRQ pulse (overflow with irq_en)
//
// Register word: [15:0] reload (write) / live counter (read), [17:16] prescaler,
// [18] count-up, [19] one-shot, [22] irq_en, [23] start.
module gba_timer_bank #(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 16,
    parameter logic [27:0] BASE_ADR = 28'h100,
    parameter int          IS_SIMU  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gb_on,
    input  logic [27:0]       bus_adr,
    input  logic [31:0]       bus_din,
    input  logic [3:0]        bus_be,
    input  logic              bus_wr,
    input  logic              bus_rd,
    output logic [31:0]       bus_dout,
    output logic              bus_rvalid,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
    logic [9:0]        pcnt_q   [NUM_CH];
    logic [9:0]        pcnt_d   [NUM_CH];
    logic [1:0]        psel_q   [NUM_CH];
    logic [1:0]        psel_d   [NUM_CH];
    logic [NUM_CH-1:0] cup_q, cup_d;
    logic [NUM_CH-1:0] oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] irqen_q, irqen_d;
    logic [NUM_CH-1:0] run_q, run_d;
    // Start edge seen while gb_on was low; the reload is applied when gb_on returns.
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       dout_q, dout_d;

    logic unused_s;
    assign unused_s = ^{bus_din[31:24], bus_din[21:20], bus_be[3], (IS_SIMU != 0)};

    // Next-state for bus reads, register writes, prescalers and the cascade chain.
    always_comb begin : p_next
        logic        carry_s;
        logic        hit_s;
        logic        wr_ctl_s;
        logic        start_edge_s;
        logic        active_s;
        logic        casc_s;
        logic        presc_hit_s;
        logic        inc_s;
        logic        ovf_s;
        logic        load_s;
        logic [15:0] new16_s;
        logic [31:0] word_s;

        carry_s  = 1'b0;
        rvalid_d = 1'b0;
        dout_d   = 32'd0;
        tick_d   = '0;
        irq_d    = '0;
        cup_d    = cup_q;
        oneshot_d = oneshot_q;
        irqen_d  = irqen_q;
        run_d    = run_q;
        pend_d   = pend_q;

        for (int i = 0; i < NUM_CH; i++) begin
            hit_s    = (bus_adr == (BASE_ADR + 28'(i)));
            wr_ctl_s = bus_wr && hit_s && bus_be[2];

            // Read samples the pre-update counter.
            word_s = 32'd0;
            word_s[CNT_W-1:0] = cnt_q[i];
            word_s[17:16]     = psel_q[i];
            word_s[18]        = cup_q[i];
            word_s[19]        = oneshot_q[i];
            word_s[22]        = irqen_q[i];
            word_s[23]        = run_q[i];
            if (bus_rd && hit_s) begin
                rvalid_d = 1'b1;
                dout_d   = word_s;
            end else begin
                rvalid_d = rvalid_d;
            end

            // Byte-merged reload; this value is also what an overflow or start
            // in the same cycle loads (write-through).
            new16_s = 16'd0;
            new16_s[CNT_W-1:0] = reload_q[i];
            new16_s[7:0]  = (bus_wr && hit_s && bus_be[0]) ? bus_din[7:0]  : new16_s[7:0];
            new16_s[15:8] = (bus_wr && hit_s && bus_be[1]) ? bus_din[15:8] : new16_s[15:8];
            reload_d[i] = new16_s[CNT_W-1:0];

            start_edge_s = wr_ctl_s && bus_din[23] && !run_q[i];
            active_s     = gb_on && run_q[i] && !pend_q[i];
            casc_s       = cup_q[i] && (i > 0);

            // >= rather than == so a prescaler change while running wraps promptly.
            case (psel_q[i])
                2'd0:    presc_hit_s = 1'b1;
                2'd1:    presc_hit_s = (pcnt_q[i] >= 10'd63);
                2'd2:    presc_hit_s = (pcnt_q[i] >= 10'd255);
                2'd3:    presc_hit_s = (pcnt_q[i] >= 10'd1023);
                default: presc_hit_s = 1'b1;
            endcase

            inc_s   = active_s && (casc_s ? carry_s : presc_hit_s);
            ovf_s   = inc_s && (cnt_q[i] == ALL_ONES);
            carry_s = ovf_s;
            load_s  = gb_on && (start_edge_s || (pend_q[i] && run_q[i]));

            if (ovf_s) begin
                cnt_d[i] = reload_d[i];
            end else if (inc_s) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (load_s) begin
                cnt_d[i] = reload_d[i];
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            if (load_s) begin
                pcnt_d[i] = 10'd0;
            end else if (active_s && !casc_s) begin
                pcnt_d[i] = presc_hit_s ? 10'd0 : (pcnt_q[i] + 10'd1);
            end else begin
                pcnt_d[i] = pcnt_q[i];
            end

            tick_d[i] = ovf_s;
            irq_d[i]  = ovf_s && irqen_q[i];

            if (wr_ctl_s) begin
                psel_d[i]    = bus_din[17:16];
                cup_d[i]     = bus_din[18];
                oneshot_d[i] = bus_din[19];
                irqen_d[i]   = bus_din[22];
            end else begin
                psel_d[i]    = psel_q[i];
            end

            // One-shot overflow wins over a start rewrite in the same cycle.
            if (ovf_s && oneshot_q[i]) begin
                run_d[i] = 1'b0;
            end else if (wr_ctl_s) begin
                run_d[i] = bus_din[23];
            end else begin
                run_d[i] = run_q[i];
            end

            if (wr_ctl_s && !bus_din[23]) begin
                pend_d[i] = 1'b0;
            end else if (start_edge_s && !gb_on) begin
                pend_d[i] = 1'b1;
            end else if (gb_on && pend_q[i] && run_q[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
                pcnt_q[i]   <= 10'd0;
                psel_q[i]   <= 2'd0;
            end
            cup_q     <= '0;
            oneshot_q <= '0;
            irqen_q   <= '0;
            run_q     <= '0;
            pend_q    <= '0;
            tick_q    <= '0;
            irq_q     <= '0;
            rvalid_q  <= 1'b0;
            dout_q    <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
                pcnt_q[i]   <= pcnt_d[i];
                psel_q[i]   <= psel_d[i];
            end
            cup_q     <= cup_d;
            oneshot_q <= oneshot_d;
            irqen_q   <= irqen_d;
            run_q     <= run_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
            dout_q    <= dout_d;
        end
    end

    assign tick       = tick_q;
    assign irq        = irq_q;
    assign bus_rvalid = rvalid_q;
    assign bus_dout   = dout_q;

endmodule

// File: tb/tb_gba_timer_bank.sv
// Self-checking bench for gba_timer_bank: a behavioural timer model is advanced
// once per clock and compared against the default build every cycle; directed
// scenarios add literal expectations, and a second CNT_W=8 build is checked
// with literal values only.
module tb_gba_timer_bank;

    localparam int          NUM_CH = 4;
    localparam logic [27:0] B      = 28'h100;
    localparam logic [27:0] B2     = 28'h200;
    localparam int          CMAX   = 32'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gb_on = 1'b1;
    logic [27:0] bus_adr = 28'd0;
    logic [31:0] bus_din = 32'd0;
    logic [3:0]  bus_be = 4'd0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [31:0] bus_dout, dout2;
    logic        bus_rvalid, rv2;
    logic [NUM_CH-1:0] tick, irq;
    logic [1:0]  tick2, irq2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state
    int       m_cnt [NUM_CH];
    int       m_rel [NUM_CH];
    int       m_pc  [NUM_CH];
    bit [1:0] m_psel[NUM_CH];
    bit       m_cup [NUM_CH];
    bit       m_os  [NUM_CH];
    bit       m_ie  [NUM_CH];
    bit       m_run [NUM_CH];
    bit       m_pend[NUM_CH];
    // expected outputs after the coming edge / currently visible
    logic [31:0]       nxt_dout, e_dout;
    logic              nxt_rv, e_rv;
    logic [NUM_CH-1:0] nxt_tick, e_tick, nxt_irq, e_irq;

    gba_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(16), .BASE_ADR(B), .IS_SIMU(1)) dut (
        .clk(clk), .reset(reset), .gb_on(gb_on), .bus_adr(bus_adr), .bus_din(bus_din),
        .bus_be(bus_be), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_dout(bus_dout),
        .bus_rvalid(bus_rvalid), .tick(tick), .irq(irq));

    gba_timer_bank #(.NUM_CH(2), .CNT_W(8), .BASE_ADR(B2), .IS_SIMU(1)) dut8 (
        .clk(clk), .reset(reset), .gb_on(gb_on), .bus_adr(bus_adr), .bus_din(bus_din),
        .bus_be(bus_be), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_dout(dout2),
        .bus_rvalid(rv2), .tick(tick2), .irq(irq2));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit carry, fired, hit, wrap;
        int div;
        int nrel[NUM_CH];
        bit old_run[NUM_CH];
        bit os_clr[NUM_CH];
        nxt_rv = 1'b0; nxt_dout = 32'd0; nxt_tick = '0; nxt_irq = '0;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0; m_rel[c] = 0; m_pc[c] = 0; m_psel[c] = 2'd0;
                m_cup[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_run[c] = 0; m_pend[c] = 0;
            end
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            hit = (bus_adr == B + 28'(c));
            if (bus_rd && hit) begin
                nxt_rv = 1'b1;
                nxt_dout = 32'(m_cnt[c]) + (32'(m_psel[c]) << 16) + (32'(m_cup[c]) << 18)
                         + (32'(m_os[c]) << 19) + (32'(m_ie[c]) << 22) + (32'(m_run[c]) << 23);
            end
            nrel[c] = m_rel[c];
            if (bus_wr && hit && bus_be[0]) nrel[c] = (nrel[c] & 32'hFF00) | int'(bus_din[7:0]);
            if (bus_wr && hit && bus_be[1]) nrel[c] = (nrel[c] & 32'h00FF) | (int'(bus_din[15:8]) << 8);
            old_run[c] = m_run[c];
        end
        carry = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            fired = 1'b0;
            if (gb_on && m_run[c] && !m_pend[c]) begin
                if (m_cup[c] && c > 0) begin
                    fired = carry;
                end else begin
                    div = (m_psel[c] == 0) ? 1 : (m_psel[c] == 1) ? 64 : (m_psel[c] == 2) ? 256 : 1024;
                    m_pc[c]++;
                    if (m_pc[c] >= div) begin fired = 1'b1; m_pc[c] = 0; end
                end
            end
            wrap  = fired && (m_cnt[c] == CMAX);
            carry = wrap;
            os_clr[c] = wrap && m_os[c];
            if (wrap) begin
                m_cnt[c] = nrel[c]; nxt_tick[c] = 1'b1; nxt_irq[c] = m_ie[c];
            end else if (fired) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            hit = (bus_adr == B + 28'(c));
            if (gb_on && m_pend[c] && old_run[c]) begin
                m_cnt[c] = nrel[c]; m_pc[c] = 0; m_pend[c] = 0;
            end
            if (bus_wr && hit && bus_be[2]) begin
                if (bus_din[23] && !old_run[c]) begin
                    if (gb_on) begin m_cnt[c] = nrel[c]; m_pc[c] = 0; end
                    else m_pend[c] = 1'b1;
                end
                if (!bus_din[23]) m_pend[c] = 1'b0;
                m_psel[c] = bus_din[17:16]; m_cup[c] = bus_din[18]; m_os[c] = bus_din[19];
                m_ie[c] = bus_din[22]; m_run[c] = bus_din[23];
            end
            if (os_clr[c]) m_run[c] = 1'b0;
            m_rel[c] = nrel[c];
        end
    endtask

    // One clock: update model, wait for the edge, publish expectations.
    task automatic cyc();
        model_step();
        @(posedge clk);
        e_rv = nxt_rv; e_dout = nxt_dout; e_tick = nxt_tick; e_irq = nxt_irq;
        #1;
    endtask

    task automatic idle();
        bus_wr = 1'b0; bus_rd = 1'b0; cyc();
    endtask

    task automatic wr(input logic [27:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_adr = a; bus_din = d; bus_be = be; bus_wr = 1'b1; bus_rd = 1'b0;
        cyc();
        bus_wr = 1'b0;
    endtask

    task automatic rd(input logic [27:0] a);
        bus_adr = a; bus_rd = 1'b1; bus_wr = 1'b0;
        cyc();
        bus_rd = 1'b0;
    endtask

    // Cycle-by-cycle comparison of the default build against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rvalid", 32'(bus_rvalid), 32'(e_rv));
            check("dout",   bus_dout, e_dout);
            check("tick",   32'(tick), 32'(e_tick));
            check("irq",    32'(irq), 32'(e_irq));
        end
    end

    initial begin
        int first, second, t0, t1, t2, t3, at3;
        bit irq_seen, same;
        int op, sel;
        logic [27:0] a;

        // reset
        reset = 1'b1; idle(); idle();
        chk_en = 1'b1;
        reset = 1'b0;
        check("rst_dout", bus_dout, 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rd(B);
        check("rst_read", bus_dout, 32'd0);
        check("rst_rv", 32'(bus_rvalid), 32'd1);

        // ch0 reload FFFE, prescaler 0, irq_en: tick every 2 cycles
        wr(B, 32'h00C0FFFE, 4'b0111);
        rd(B); check("s1_rd0", bus_dout, 32'h00C0FFFE); check("s1_tick0", 32'(tick), 32'd0);
        rd(B); check("s1_rd1", bus_dout, 32'h00C0FFFF); check("s1_tick1", 32'(tick), 32'd1);
        check("s1_irq1", 32'(irq), 32'd1);
        rd(B); check("s1_rd2", bus_dout, 32'h00C0FFFE); check("s1_tick2", 32'(tick), 32'd0);
        wr(B, 32'h0, 4'b0100);

        // ch1 div 64, reload FFFF, no irq
        wr(B + 28'd1, 32'h0081FFFF, 4'b0111);
        first = 0; second = 0; irq_seen = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            idle();
            if (tick[1]) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
            if (irq[1]) irq_seen = 1'b1;
        end
        check("s2_first", 32'(first), 32'd64);
        check("s2_second", 32'(second), 32'd128);
        check("s2_irq", 32'(irq_seen), 32'd0);
        wr(B + 28'd1, 32'h0, 4'b0100);

        // cascade ch0 -> ch1 -> ch2
        wr(B + 28'd1, 32'h0084FFFE, 4'b0111);
        wr(B + 28'd2, 32'h0084FFFF, 4'b0111);
        idle(); idle();
        rd(B + 28'd2); check("s3_ch2_idle", bus_dout, 32'h0084FFFF);
        wr(B, 32'h0080FFFF, 4'b0111);
        t0 = 0; t1 = 0; t2 = 0; same = 1'b1;
        for (int n = 0; n < 10; n++) begin
            idle();
            t0 += int'(tick[0]); t1 += int'(tick[1]); t2 += int'(tick[2]);
            if (tick[2] != tick[1]) same = 1'b0;
        end
        check("s3_t0", 32'(t0), 32'd10);
        check("s3_t1", 32'(t1), 32'd5);
        check("s3_t2", 32'(t2), 32'd5);
        check("s3_same", 32'(same), 32'd1);
        wr(B, 32'h0, 4'b0100); wr(B + 28'd1, 32'h0, 4'b0100); wr(B + 28'd2, 32'h0, 4'b0100);

        // one-shot ch3
        wr(B + 28'd3, 32'h0088FFFD, 4'b0111);
        t3 = 0; at3 = 0;
        for (int n = 1; n <= 8; n++) begin
            idle();
            if (tick[3]) begin t3++; at3 = n; end
        end
        check("s4_count", 32'(t3), 32'd1);
        check("s4_when", 32'(at3), 32'd3);
        rd(B + 28'd3); check("s4_read", bus_dout, 32'h0008FFFD);

        // stop at 0x1234, hold, restart, start rewrite while running
        wr(B, 32'h00801230, 4'b0111);
        idle(); idle(); idle();
        wr(B, 32'h0, 4'b0100);
        for (int n = 0; n < 10; n++) begin
            rd(B); check("s5_hold", bus_dout, 32'h00001234);
        end
        wr(B, 32'h00005555, 4'b0011);
        wr(B, 32'h00800000, 4'b0100);
        rd(B); check("s5_restart", bus_dout, 32'h00805555);
        wr(B, 32'h00800000, 4'b0100);
        rd(B); check("s5_noreload", bus_dout, 32'h00805557);
        wr(B, 32'h0, 4'b0100);

        // CNT_W = 8 build
        wr(B2, 32'h00C000FE, 4'b0111);
        rd(B2); check("w8_rd0", dout2, 32'h00C000FE);
        rd(B2); check("w8_rd1", dout2, 32'h00C000FF);
        check("w8_tick", 32'(tick2), 32'd1);
        check("w8_irq", 32'(irq2), 32'd1);
        reset = 1'b1; idle(); reset = 1'b0;
        check("w8_rst_tick", 32'(tick2), 32'd0);
        check("w8_rst_irq", 32'(irq2), 32'd0);
        check("w8_rst_rv", 32'(rv2), 32'd0);
        check("w8_rst_dout", dout2, 32'd0);
        rd(B2); check("w8_rst_read", dout2, 32'd0); check("w8_rst_rv2", 32'(rv2), 32'd1);
        wr(B2, 32'h0000ABCD, 4'b0011);
        wr(B2, 32'h00800000, 4'b0100);
        rd(B2); check("w8_high_zero", dout2, 32'h008000CD);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            reset  = ($urandom_range(0, 299) == 0);
            gb_on  = ($urandom_range(0, 9) != 0);
            sel    = $urandom_range(0, NUM_CH + 1);
            a      = (sel == NUM_CH) ? (B - 28'd1) :
                     (sel == NUM_CH + 1) ? (B + 28'(NUM_CH)) : (B + 28'(sel));
            op     = $urandom_range(0, 9);
            bus_adr = a;
            bus_din[15:0]  = 16'hFFFF - 16'($urandom_range(0, 20));
            bus_din[17:16] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus_din[18]    = 1'($urandom);
            bus_din[19]    = ($urandom_range(0, 3) == 0);
            bus_din[21:20] = 2'($urandom);
            bus_din[22]    = 1'($urandom);
            bus_din[23]    = ($urandom_range(0, 3) != 0);
            bus_din[31:24] = 8'($urandom);
            bus_be  = 4'($urandom);
            bus_wr  = (op <= 2) || (op == 6);
            bus_rd  = (op >= 3) && (op <= 6);
            cyc();
        end
        reset = 1'b0; gb_on = 1'b1;
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gba_timer_bank.md
Name: gba_timer_bank

Overview:
- Parametrised bank of NUM_CH GBA-style timers sharing one 32-bit register bus.
- Each channel has: a reload value, a prescaler (1/64/256/1024), cascade count-up, an IRQ enable, start/stop, and a one-shot mode.
- Cascade from channel i-1 to channel i has zero cycle lag, so a full chain overflows in the same clock.
- Sits beside the IRQ controller and the sound FIFOs. It drives per-channel tick and IRQ pulses.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 16, counter/reload width in bits (1..16); bits above CNT_W read as zero.
- BASE_ADR, 'h100, word address of channel 0; channel i is at BASE_ADR+i.
- IS_SIMU, 0, simulation-only flag; no functional effect.

Ports:
- clk, in, 1, system clock (16.7 MHz).
- reset, in, 1, reset; synchronous, active-high; clock clk.
- gb_on, in, 1, global enable; when low, all channel state freezes (bus still works).
- bus_adr, in, 28, word address.
- bus_din, in, 32, write data.
- bus_be, in, 4, byte enables for writes.
- bus_wr, in, 1, write strobe (1 cycle).
- bus_rd, in, 1, read strobe (1 cycle).
- bus_dout, out, 32, read data; zero when bus_rvalid is low.
- bus_rvalid, out, 1, read data valid.
- tick, out, NUM_CH, 1-cycle overflow pulse per channel.
- irq, out, NUM_CH, 1-cycle IRQ pulse per channel.

Behaviour:
- Register word layout per channel:
  - [15:0]: write = reload (low CNT_W bits), read = live counter.
  - [17:16]: prescaler.
  - [18]: count-up.
  - [19]: one-shot.
  - [22]: irq_en.
  - [23]: start.
  - Other bits read 0.
- Write byte enables: be[0]/be[1] write the reload bytes; be[2] writes the control byte; be[3] is ignored.
- Reset: all counters, reloads, control bits and prescale counters = 0; tick = irq = 0; bus_rvalid = 0; bus_dout = 0.
- Read: bus_rd to a channel address -> bus_rvalid = 1 and bus_dout valid the next cycle. Counter value is sampled as of the cycle of bus_rd (pre-update value). Address outside the bank -> bus_rvalid stays 0.
- Start edge: a write with be[2], bit23 = 1, while the channel is stopped:
  - next cycle, counter <= reload value (including a reload written in the same write) and prescale counter <= 0;
  - counting begins the cycle after.
  - Writing start = 1 while already running: no reload, no prescaler reset.
- Stop: a write with bit23 = 0 makes running = 0 from the next cycle. The counter holds its value and remains readable.
- Increment source, per running channel:
  - count-up = 1 and i > 0: increment on the same-cycle overflow of channel i-1 (combinational chain). The prescaler is ignored.
  - otherwise (including channel 0 with count-up = 1): prescaler 0 increments every cycle. Prescaler n increments when prescale counter >= div-1, where div = 64/256/1024; the prescale counter then resets to 0, else it increments by 1.
  - The prescaler may change while running; the >= compare guarantees wrap on the next cycle.
- Overflow = increment while counter == all-ones (CNT_W). On overflow:
  - counter <= reload;
  - tick[i] = 1 the next cycle;
  - irq[i] = 1 the next cycle if irq_en.
  - If one-shot: running <= 0 (read-back bit23 clears).
- Reload written while running takes effect at the next overflow. A reload written in the same cycle as an overflow is used for that reload (write-through).
- Stop write in the same cycle as an overflow: tick/irq still pulse, counter reloads, channel stops.
- gb_on low: counters, prescale counters, running and outputs are held. tick/irq = 0. Register writes still update reload and control; a start edge is captured and applied when gb_on returns.
- reset mid-count: all state is cleared the next cycle; no tick/irq is emitted in that cycle.

Test Plan:
- Ch0 reload 0xFFFE, prescaler 0, irq_en, start -> counter reads 0xFFFE, 0xFFFF, then wraps to 0xFFFE; tick[0] and irq[0] pulse exactly every 2 cycles.
- Ch1 prescaler 1 (div 64), reload 0xFFFF -> first tick[1] exactly 64 cycles after counting begins, then every 64 cycles; irq[1] stays 0 with irq_en = 0.
- Cascade: ch0 reload 0xFFFF prescaler 0; ch1 count-up, reload 0xFFFE; ch2 count-up, reload 0xFFFF -> tick[1] every 2 cycles and tick[2] in the same cycle as tick[1]; ch2 never advances without ch1 overflow.
- One-shot: ch3 reload 0xFFFD, one-shot, start -> single tick[3] after 3 increments; bit23 reads 0 afterwards; counter reads 0xFFFD and holds.
- Stop/restart: stop ch0 at counter 0x1234 -> reads 0x1234 for 10 cycles; write start again -> counter reloads to the current reload value; start = 1 rewrite while running -> no reload.
- CNT_W = 8 build: reload 0xFE -> overflow at 0xFF; read returns bits [15:8] = 0; reset asserted mid-count -> all outputs 0 and counter reads 0 the next cycle.
